dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array, the successor to the 2-way dcache SRAM used by the L1 dcache controller. Adds true-LRU replacement across any power-of-two way count, separate valid/dirty state, victim reporting for write-back, and a sequential flush engine. The flush engine drains dirty lines to memory over a valid/ready handshake. Sits between the dcache controller FSM and the data memory interface.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_lru_ages.sv | 54 +++++
 rtl/dcache_sram_nway.sv | 191 +++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the N-way dcache storage array.
package dcache_pkg;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_SCAN,
        FL_WB,
        FL_DONE
    } fl_state_t;

    // The metadata struct is fixed-width, so the array's TAG_W must match this value.
    localparam int DC_TAG_W = 23;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [DC_TAG_W-1:0] tag;
    } line_meta_t;

    function automatic int clog2_f(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/dcache_lru_ages.sv
// Per-set true-LRU age storage: touch update, flush reinitialisation and victim selection.
module dcache_lru_ages
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int SET_W   = clog2_f(NUM_SETS),
    localparam int WAY_W   = clog2_f(NUM_WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                touch_i,
    input  logic [SET_W-1:0]    touch_set_i,
    input  logic [WAY_W-1:0]    touch_way_i,
    input  logic                reinit_i,
    input  logic [SET_W-1:0]    rd_set_i,
    input  logic [NUM_WAYS-1:0] rd_valid_i,
    output logic [WAY_W-1:0]    victim_way_o
);

    logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];

    // Age 0 is most recently used; ages stay a permutation of 0..NUM_WAYS-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else if (reinit_i) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else if (touch_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way_i)
                    age_q[touch_set_i][w] <= '0;
                else if (age_q[touch_set_i][w] < age_q[touch_set_i][touch_way_i])
                    age_q[touch_set_i][w] <= age_q[touch_set_i][w] + 1'b1;
            end
        end
    end

    // Lowest invalid way wins; the reverse scans let the lowest index overwrite last.
    always_comb begin
        victim_way_o = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (age_q[rd_set_i][w] == WAY_W'(NUM_WAYS - 1))
                victim_way_o = WAY_W'(w);
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!rd_valid_i[w])
                victim_way_o = WAY_W'(w);
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU replacement, victim reporting
// and a sequential flush engine that drains dirty lines over a valid/ready port.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = DC_TAG_W,
    parameter int LINE_W   = 256,
    localparam int SET_W   = clog2_f(NUM_SETS),
    localparam int WAY_W   = clog2_f(NUM_WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [SET_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              hit_o,
    output logic [WAY_W-1:0]  hit_way_o,
    output logic [LINE_W-1:0] data_o,
    output logic              victim_valid_o,
    output logic              victim_dirty_o,
    output logic [TAG_W-1:0]  victim_tag_o,
    output logic [LINE_W-1:0] victim_data_o,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [SET_W-1:0]  wb_set_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o,
    output logic              flush_done_o
);

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

    fl_state_t              state_q, state_n;
    logic [SET_W+WAY_W-1:0] ptr_q;
    logic [SET_W-1:0]       ptr_set;
    logic [WAY_W-1:0]       ptr_way;
    logic ptr_clear, ptr_adv, clear_line, ages_reinit, last_line, ptr_dirty;

    line_meta_t          set_meta [NUM_WAYS];
    logic [NUM_WAYS-1:0] match;
    logic [WAY_W-1:0]    match_way, victim_way, wr_way;
    logic any_match, flush_start, access_ok, wr_en, touch;

    assign ptr_set   = ptr_q[SET_W+WAY_W-1:WAY_W];
    assign ptr_way   = ptr_q[WAY_W-1:0];
    assign last_line = &ptr_q;
    assign ptr_dirty = valid_q[ptr_set][ptr_way] & dirty_q[ptr_set][ptr_way];

    always_comb begin
        match     = '0;
        match_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            set_meta[w] = '{valid: valid_q[addr_i][w], dirty: dirty_q[addr_i][w], tag: tag_q[addr_i][w]};
            match[w]    = set_meta[w].valid && (set_meta[w].tag == tag_i);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (match[w])
                match_way = WAY_W'(w);
    end

    // A flush start takes priority: the coincident access neither writes nor ages.
    assign any_match   = |match;
    assign busy_o      = (state_q != FL_IDLE);
    assign flush_start = flush_i & (state_q == FL_IDLE);
    assign access_ok   = enable_i & ~busy_o & ~flush_start;
    assign wr_en       = access_ok & write_i;
    assign wr_way      = any_match ? match_way : victim_way;
    assign touch       = access_ok & (any_match | write_i);

    assign hit_o     = enable_i & ~busy_o & any_match;
    assign hit_way_o = hit_o ? match_way : '0;
    assign data_o    = hit_o ? data_q[addr_i][match_way] : '0;

    assign victim_valid_o = set_meta[victim_way].valid;
    assign victim_dirty_o = set_meta[victim_way].dirty;
    assign victim_tag_o   = set_meta[victim_way].tag;
    assign victim_data_o  = data_q[addr_i][victim_way];

    assign wb_set_o  = ptr_set;
    assign wb_tag_o  = tag_q[ptr_set][ptr_way];
    assign wb_data_o = data_q[ptr_set][ptr_way];

    dcache_lru_ages #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .touch_i      (touch),
        .touch_set_i  (addr_i),
        .touch_way_i  (wr_way),
        .reinit_i     (ages_reinit),
        .rd_set_i     (addr_i),
        .rd_valid_i   (valid_q[addr_i]),
        .victim_way_o (victim_way)
    );

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            data_q[addr_i][wr_way] <= data_i;
            if (!any_match)
                tag_q[addr_i][wr_way] <= tag_i;
        end
    end

    // Writes and flush clears never coincide: writes need busy_o low, clears need it high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (wr_en) begin
                valid_q[addr_i][wr_way] <= 1'b1;
                dirty_q[addr_i][wr_way] <= any_match ? (dirty_q[addr_i][wr_way] | dirty_i) : dirty_i;
            end
            if (clear_line) begin
                valid_q[ptr_set][ptr_way] <= 1'b0;
                dirty_q[ptr_set][ptr_way] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FL_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_n;
            if (ptr_clear)
                ptr_q <= '0;
            else if (ptr_adv)
                ptr_q <= ptr_q + 1'b1;
        end
    end

    // The pointer walks way-first because the way index sits in its low bits.
    always_comb begin
        state_n      = state_q;
        ptr_clear    = 1'b0;
        ptr_adv      = 1'b0;
        clear_line   = 1'b0;
        ages_reinit  = 1'b0;
        wb_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (flush_i) begin
                    state_n   = FL_SCAN;
                    ptr_clear = 1'b1;
                end
            end
            FL_SCAN: begin
                if (ptr_dirty) begin
                    state_n = FL_WB;
                end else begin
                    clear_line = 1'b1;
                    ptr_adv    = 1'b1;
                    if (last_line)
                        state_n = FL_DONE;
                end
            end
            FL_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    clear_line = 1'b1;
                    ptr_adv    = 1'b1;
                    state_n    = last_line ? FL_DONE : FL_SCAN;
                end
            end
            FL_DONE: begin
                flush_done_o = 1'b1;
                ages_reinit  = 1'b1;
                state_n      = FL_IDLE;
            end
            default: state_n = FL_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway (16 sets, 4 ways, 23-bit tags).
module tb_dcache_sram_nway;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i, write_i, dirty_i, flush_i, wb_ready_i;
    logic [3:0]   addr_i;
    logic [22:0]  tag_i;
    logic [255:0] data_i;
    logic         hit_o, victim_valid_o, victim_dirty_o, busy_o, wb_valid_o, flush_done_o;
    logic [1:0]   hit_way_o;
    logic [255:0] data_o, victim_data_o, wb_data_o;
    logic [22:0]  victim_tag_o, wb_tag_o;
    logic [3:0]   wb_set_o;

    int checks = 0;
    int errors = 0;

    logic [3:0]   expWbSet  [2];
    logic [22:0]  expWbTag  [2];
    logic [255:0] expWbData [2];
    int           expWbNum;

    int cycles, wbs, firstLen, n;
    bit doneSeen;
    logic [255:0] pat55;

    dcache_sram_nway dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .write_i        (write_i),
        .addr_i         (addr_i),
        .tag_i          (tag_i),
        .data_i         (data_i),
        .dirty_i        (dirty_i),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .data_o         (data_o),
        .victim_valid_o (victim_valid_o),
        .victim_dirty_o (victim_dirty_o),
        .victim_tag_o   (victim_tag_o),
        .victim_data_o  (victim_data_o),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_set_o       (wb_set_o),
        .wb_tag_o       (wb_tag_o),
        .wb_data_o      (wb_data_o),
        .flush_done_o   (flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] lineOf(input logic [22:0] tag);
        return {8{9'd0, tag}};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic wr, input logic [3:0] set,
                                 input logic [22:0] tag, input logic [255:0] data, input logic dirty);
        enable_i = en;
        write_i  = wr;
        addr_i   = set;
        tag_i    = tag;
        data_i   = data;
        dirty_i  = dirty;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic fill(input logic [3:0] set, input logic [22:0] tag, input logic dirty);
        applyStimulus(1'b1, 1'b1, set, tag, lineOf(tag), dirty);
        tick();
    endtask

    task automatic lookup(input string name, input logic [3:0] set, input logic [22:0] tag,
                          input logic expHit, input logic [1:0] expWay);
        applyStimulus(1'b1, 1'b0, set, tag, '0, 1'b0);
        checkOutput({name, ".hit"}, 256'(hit_o), 256'(expHit));
        checkOutput({name, ".way"}, 256'(hit_way_o), 256'(expWay));
        if (expHit)
            checkOutput({name, ".data"}, data_o, lineOf(tag));
        else
            checkOutput({name, ".data"}, data_o, '0);
        tick();
    endtask

    // Runs from the cycle after the flush pulse until flush_done_o, holding the
    // first write-back's ready low for 'stalls' cycles.
    task automatic runFlush(input int stalls, output int cyc, output int wbCount,
                            output int firstCyc, output bit done);
        int k;
        bit hs;
        k = 0;
        cyc = 0;
        wbCount = 0;
        firstCyc = 0;
        done = 1'b0;
        while (k < 300 && !done) begin
            k++;
            hs = 1'b0;
            if (wb_valid_o) begin
                if (wbCount < expWbNum) begin
                    checkOutput("wbSet", 256'(wb_set_o), 256'(expWbSet[wbCount]));
                    checkOutput("wbTag", 256'(wb_tag_o), 256'(expWbTag[wbCount]));
                    checkOutput("wbData", wb_data_o, expWbData[wbCount]);
                end else begin
                    checkOutput("wbUnexpected", 256'(wb_valid_o), 256'(1'b0));
                end
                if (wbCount == 0)
                    firstCyc++;
                wb_ready_i = (wbCount == 0 && firstCyc <= stalls) ? 1'b0 : 1'b1;
                hs = wb_ready_i;
            end else begin
                wb_ready_i = 1'b0;
            end
            if (flush_done_o) begin
                done = 1'b1;
                cyc  = k;
            end
            tick();
            if (hs)
                wbCount++;
        end
        wb_ready_i = 1'b0;
    endtask

    initial begin
        pat55 = {32{8'h55}};
        rst_i = 1'b1;
        flush_i = 1'b0;
        wb_ready_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        #11;
        checkOutput("rst.hit", 256'(hit_o), 256'(1'b0));
        checkOutput("rst.busy", 256'(busy_o), 256'(1'b0));
        checkOutput("rst.wbValid", 256'(wb_valid_o), 256'(1'b0));
        checkOutput("rst.flushDone", 256'(flush_done_o), 256'(1'b0));
        checkOutput("rst.victimValid", 256'(victim_valid_o), 256'(1'b0));
        checkOutput("rst.victimDirty", 256'(victim_dirty_o), 256'(1'b0));
        rst_i = 1'b0;
        tick();

        applyStimulus(1'b1, 1'b0, 4'd3, 23'h1ABC, '0, 1'b0);
        checkOutput("cold.victimValid", 256'(victim_valid_o), 256'(1'b0));
        tick();
        lookup("cold", 4'd3, 23'h1ABC, 1'b0, 2'd0);

        // Set 5: A,B,C,D fill ways 0..3; reading A leaves B as LRU.
        fill(4'd5, 23'hA, 1'b0);
        fill(4'd5, 23'hB, 1'b0);
        fill(4'd5, 23'hC, 1'b0);
        fill(4'd5, 23'hD, 1'b0);
        lookup("readA", 4'd5, 23'hA, 1'b1, 2'd0);

        applyStimulus(1'b1, 1'b1, 4'd5, 23'hE, lineOf(23'hE), 1'b0);
        checkOutput("fillE.victimValid", 256'(victim_valid_o), 256'(1'b1));
        checkOutput("fillE.victimTag", 256'(victim_tag_o), 256'(23'hB));
        checkOutput("fillE.victimDirty", 256'(victim_dirty_o), 256'(1'b0));
        tick();
        lookup("missB", 4'd5, 23'hB, 1'b0, 2'd0);
        lookup("hitE", 4'd5, 23'hE, 1'b1, 2'd1);

        applyStimulus(1'b1, 1'b1, 4'd5, 23'hC, pat55, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd5, 23'hC, '0, 1'b0);
        checkOutput("wrC.hit", 256'(hit_o), 256'(1'b1));
        checkOutput("wrC.way", 256'(hit_way_o), 256'(2'd2));
        checkOutput("wrC.data", data_o, pat55);
        tick();

        // Touch D, E, A so C ages to LRU.
        lookup("touchD", 4'd5, 23'hD, 1'b1, 2'd3);
        lookup("touchE", 4'd5, 23'hE, 1'b1, 2'd1);
        lookup("touchA", 4'd5, 23'hA, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 23'hF, '0, 1'b0);
        checkOutput("lruC.hit", 256'(hit_o), 256'(1'b0));
        checkOutput("lruC.victimDirty", 256'(victim_dirty_o), 256'(1'b1));
        checkOutput("lruC.victimTag", 256'(victim_tag_o), 256'(23'hC));
        checkOutput("lruC.victimData", victim_data_o, pat55);
        tick();

        fill(4'd9, 23'h77, 1'b1);

        // Full flush: dirty C (set 5) then 0x77 (set 9), 3 stall cycles on the first.
        expWbNum = 2;
        expWbSet[0] = 4'd5; expWbTag[0] = 23'hC;  expWbData[0] = pat55;
        expWbSet[1] = 4'd9; expWbTag[1] = 23'h77; expWbData[1] = lineOf(23'h77);
        flush_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        tick();
        flush_i = 1'b0;
        checkOutput("flush.busy", 256'(busy_o), 256'(1'b1));
        runFlush(3, cycles, wbs, firstLen, doneSeen);
        checkOutput("flush.doneSeen", 256'(doneSeen), 256'(1'b1));
        checkOutput("flush.cycles", 256'(cycles), 256'(70));
        checkOutput("flush.wbCount", 256'(wbs), 256'(2));
        checkOutput("flush.firstWbCycles", 256'(firstLen), 256'(4));
        checkOutput("flush.busyAfter", 256'(busy_o), 256'(1'b0));
        checkOutput("flush.doneAfter", 256'(flush_done_o), 256'(1'b0));
        lookup("postA", 4'd5, 23'hA, 1'b0, 2'd0);
        lookup("postC", 4'd5, 23'hC, 1'b0, 2'd0);
        lookup("postE", 4'd5, 23'hE, 1'b0, 2'd0);
        lookup("post77", 4'd9, 23'h77, 1'b0, 2'd0);

        // Reset while a write-back is pending.
        fill(4'd1, 23'h10, 1'b1);
        fill(4'd1, 23'h11, 1'b0);
        flush_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        tick();
        flush_i = 1'b0;
        n = 0;
        while (!wb_valid_o && n < 100) begin
            tick();
            n++;
        end
        checkOutput("midRst.wbReached", 256'(wb_valid_o), 256'(1'b1));
        applyStimulus(1'b1, 1'b0, 4'd1, 23'h10, '0, 1'b0);
        checkOutput("midRst.busyLookupHit", 256'(hit_o), 256'(1'b0));
        rst_i = 1'b1;
        #1;
        checkOutput("midRst.wbValid", 256'(wb_valid_o), 256'(1'b0));
        checkOutput("midRst.busy", 256'(busy_o), 256'(1'b0));
        checkOutput("midRst.flushDone", 256'(flush_done_o), 256'(1'b0));
        tick();
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        lookup("midRst10", 4'd1, 23'h10, 1'b0, 2'd0);
        lookup("midRst11", 4'd1, 23'h11, 1'b0, 2'd0);

        // Flush pulse coinciding with a dirty fill: the fill must be dropped.
        expWbNum = 0;
        flush_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd2, 23'h22, lineOf(23'h22), 1'b1);
        tick();
        flush_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        runFlush(0, cycles, wbs, firstLen, doneSeen);
        checkOutput("simul.doneSeen", 256'(doneSeen), 256'(1'b1));
        checkOutput("simul.cycles", 256'(cycles), 256'(65));
        checkOutput("simul.wbCount", 256'(wbs), 256'(0));
        lookup("simul22", 4'd2, 23'h22, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
